// File: rtl/ooo_types.sv
// Shared out-of-order core types: renamed instruction entry and tag widths.
package ooo_types;

  localparam int PHYS_REG_BITS = 6;
  localparam int ROB_BITS      = 5;

  typedef struct packed {
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
    logic                     prs1_ready;
    logic                     prs2_ready;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [ROB_BITS-1:0]      rob_tag;
    logic [31:0]              immediate;
    logic                     mem_read;
    logic                     mem_write;
    logic                     reg_write;
  } rs_entry_t;

endpackage

// File: rtl/lsu_iq_wakeup_match.sv
// Compares one physical register tag against every writeback channel.
// Register 0 is architecturally always ready, so it always reports a hit.
module lsu_iq_wakeup_match
  import ooo_types::*;
#(
  parameter int NUM_WB = 2
) (
  input  logic [PHYS_REG_BITS-1:0]             tag,
  input  logic [NUM_WB-1:0]                    wb_en,
  input  logic [NUM_WB-1:0][PHYS_REG_BITS-1:0] wb_prd,
  output logic                                 hit
);

  always_comb begin
    // NOTE: hit gets a value before the loop so no path leaves it unassigned (no latch).
    hit = (tag == '0);
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_en[i] && (wb_prd[i] == tag)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/lsu_issue_queue.sv
// In-order issue queue feeding the LSU; only the head entry may issue.
// Define LSU_IQ_WAKEUP_BYPASS_EN to let same-cycle writebacks make the head eligible.
module lsu_issue_queue
  import ooo_types::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 dispatch_valid,
  input  rs_entry_t                            dispatch_entry,
  output logic                                 dispatch_ready,
  input  logic [NUM_WB-1:0]                    wb_en,
  input  logic [NUM_WB-1:0][PHYS_REG_BITS-1:0] wb_prd,
  input  logic                                 lsu_ready,
  output logic                                 issue_en,
  output rs_entry_t                            issue_entry,
  output logic [$clog2(DEPTH):0]               count,
  input  logic                                 flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic      valid;
    rs_entry_t e;
  } iq_slot_t;

  iq_slot_t        slots [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [DEPTH-1:0] hit1, hit2;
  logic             disp_hit1, disp_hit2;
  rs_entry_t        disp_entry;
  iq_slot_t         head_slot;
  logic             rdy1, rdy2, eligible, do_dispatch;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry_match
    lsu_iq_wakeup_match #(.NUM_WB(NUM_WB)) u_match1 (
      .tag(slots[g].e.prs1), .wb_en(wb_en), .wb_prd(wb_prd), .hit(hit1[g]));
    lsu_iq_wakeup_match #(.NUM_WB(NUM_WB)) u_match2 (
      .tag(slots[g].e.prs2), .wb_en(wb_en), .wb_prd(wb_prd), .hit(hit2[g]));
  end

  lsu_iq_wakeup_match #(.NUM_WB(NUM_WB)) u_disp_match1 (
    .tag(dispatch_entry.prs1), .wb_en(wb_en), .wb_prd(wb_prd), .hit(disp_hit1));
  lsu_iq_wakeup_match #(.NUM_WB(NUM_WB)) u_disp_match2 (
    .tag(dispatch_entry.prs2), .wb_en(wb_en), .wb_prd(wb_prd), .hit(disp_hit2));

  always_comb begin
    disp_entry            = dispatch_entry;
    disp_entry.prs1_ready = dispatch_entry.prs1_ready | disp_hit1;
    disp_entry.prs2_ready = dispatch_entry.prs2_ready | disp_hit2;
  end

  assign head_slot = slots[head];

`ifdef LSU_IQ_WAKEUP_BYPASS_EN
  assign rdy1 = head_slot.e.prs1_ready | hit1[head];
  assign rdy2 = head_slot.e.prs2_ready | hit2[head];
`else
  assign rdy1 = head_slot.e.prs1_ready;
  assign rdy2 = head_slot.e.prs2_ready;
`endif

  // Loads never wait on prs2; stores need both address and data operands.
  assign eligible       = head_slot.valid && rdy1 && (!head_slot.e.mem_write || rdy2);
  assign issue_en       = eligible && lsu_ready && !flush;
  assign issue_entry    = head_slot.e;
  assign dispatch_ready = (count < CNT_W'(DEPTH));
  assign do_dispatch    = dispatch_valid && dispatch_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset too, because issue_entry must read all zeros out of reset.
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) slots[i].valid <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // NOTE: non-blocking assignments, so later writes in this block override earlier ones
      // while every read sees the pre-edge state.
      for (int i = 0; i < DEPTH; i++) begin
        if (slots[i].valid) begin
          if (hit1[i]) slots[i].e.prs1_ready <= 1'b1;
          if (hit2[i]) slots[i].e.prs2_ready <= 1'b1;
        end
      end
      // The tail slot is free whenever dispatch is accepted, so it never collides with wakeup.
      if (do_dispatch) begin
        slots[tail] <= '{valid: 1'b1, e: disp_entry};
        tail        <= tail + PTR_W'(1);
      end
      if (issue_en) begin
        slots[head].valid <= 1'b0;
        head              <= head + PTR_W'(1);
      end
      case ({do_dispatch, issue_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Scoreboard bench for lsu_issue_queue: expected rob_tags are queued at dispatch
// and popped by a monitor whenever the DUT issues.
module tb_lsu_issue_queue;
  import ooo_types::*;

`ifdef LSU_IQ_WAKEUP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          dispatch_valid;
  rs_entry_t                     dispatch_entry;
  logic                          dispatch_ready;
  logic [1:0]                    wb_en;
  logic [1:0][PHYS_REG_BITS-1:0] wb_prd;
  logic                          lsu_ready;
  logic                          issue_en;
  rs_entry_t                     issue_entry;
  logic [3:0]                    count;
  logic                          flush;

  int total = 0;
  int bad   = 0;
  logic [ROB_BITS-1:0] sb[$];

  lsu_issue_queue #(.DEPTH(8), .NUM_WB(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .dispatch_valid(dispatch_valid), .dispatch_entry(dispatch_entry),
    .dispatch_ready(dispatch_ready),
    .wb_en(wb_en), .wb_prd(wb_prd),
    .lsu_ready(lsu_ready), .issue_en(issue_en), .issue_entry(issue_entry),
    .count(count), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && issue_en === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL issue_order: got rob_tag %0d expected no issue", issue_entry.rob_tag);
      end else begin
        logic [ROB_BITS-1:0] exp_tag;
        exp_tag = sb.pop_front();
        if (issue_entry.rob_tag !== exp_tag) begin
          bad++;
          $display("FAIL issue_order: got rob_tag %0d expected %0d", issue_entry.rob_tag, exp_tag);
        end
      end
    end
  end

  function automatic rs_entry_t mk(input int rob, input int p1, input logic r1,
                                   input int p2, input logic r2, input logic st);
    rs_entry_t e;
    e            = '0;
    e.rob_tag    = ROB_BITS'(rob);
    e.prs1       = PHYS_REG_BITS'(p1);
    e.prs1_ready = r1;
    e.prs2       = PHYS_REG_BITS'(p2);
    e.prs2_ready = r2;
    e.prd        = {1'b1, ROB_BITS'(rob)};
    e.immediate  = 32'h100 + rob;
    e.mem_read   = ~st;
    e.mem_write  = st;
    e.reg_write  = ~st;
    return e;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (count != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_count", 64'(count), 64'd0);
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; dispatch_valid = 1'b0; dispatch_entry = '0;
    wb_en = '0; wb_prd = '0; lsu_ready = 1'b0; flush = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_issue_en", 64'(issue_en), 64'd0);
    check("rst_dispatch_ready", 64'(dispatch_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_issue_entry", 64'(issue_entry), 64'd0);
    nxt();
    rst_n = 1'b1;

    // Single ready load: issues the cycle after dispatch
    lsu_ready = 1'b1; dispatch_valid = 1'b1; dispatch_entry = mk(1, 5, 1, 0, 0, 0);
    sb.push_back(5'd1);
    @(negedge clk);
    check("t1_count0", 64'(count), 64'd0);
    check("t1_no_issue_empty", 64'(issue_en), 64'd0);
    nxt();
    dispatch_valid = 1'b0;
    @(negedge clk);
    check("t1_count1", 64'(count), 64'd1);
    check("t1_issue", 64'(issue_en), 64'd1);
    nxt();
    @(negedge clk);
    check("t1_count_back0", 64'(count), 64'd0);
    nxt();

    // Store waiting on prs2 blocks the younger load
    dispatch_valid = 1'b1; dispatch_entry = mk(2, 3, 1, 7, 0, 1); sb.push_back(5'd2);
    nxt();
    dispatch_entry = mk(3, 3, 1, 12, 0, 0); sb.push_back(5'd3);
    @(negedge clk);
    check("t2_store_blocked", 64'(issue_en), 64'd0);
    nxt();
    dispatch_valid = 1'b0;
    @(negedge clk);
    check("t2_still_blocked", 64'(issue_en), 64'd0);
    check("t2_count2", 64'(count), 64'd2);
    nxt();
    wb_en = 2'b01; wb_prd[0] = 6'd7;
    @(negedge clk);
    check("t2_wake_cycle_issue", 64'(issue_en), 64'(BYP));
    nxt();
    wb_en = '0;
    @(negedge clk);
    check("t2_after_wake_issue", 64'(issue_en), 64'd1);
    nxt();
    wait_empty(6);

    // Fill with nothing ready
    for (int i = 0; i < 8; i++) begin
      dispatch_valid = 1'b1; dispatch_entry = mk(4 + i, 20 + i, 0, 0, 0, 0);
      sb.push_back(ROB_BITS'(4 + i));
      nxt();
    end
    dispatch_valid = 1'b0;
    @(negedge clk);
    check("t3_full_count", 64'(count), 64'd8);
    check("t3_full_not_ready", 64'(dispatch_ready), 64'd0);
    check("t3_full_no_issue", 64'(issue_en), 64'd0);
    nxt();
    lsu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_en = 2'b11; wb_prd[0] = 6'(20 + 2 * i); wb_prd[1] = 6'(21 + 2 * i);
      nxt();
    end
    wb_en = '0;
    // First issue cycle with dispatch held: still rejected (prs1=0 is always ready)
    lsu_ready = 1'b1; dispatch_valid = 1'b1; dispatch_entry = mk(12, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t3_first_issue", 64'(issue_en), 64'd1);
    check("t3_first_issue_reject", 64'(dispatch_ready), 64'd0);
    check("t3_first_issue_count", 64'(count), 64'd8);
    nxt();
    sb.push_back(5'd12);
    @(negedge clk);
    check("t3_accept_count", 64'(count), 64'd7);
    check("t3_accept_ready", 64'(dispatch_ready), 64'd1);
    nxt();
    for (int k = 13; k < 24; k++) begin
      dispatch_entry = mk(k, 0, 1, 0, 0, 0);
      sb.push_back(ROB_BITS'(k));
      @(negedge clk);
      check("t3_wrap_count", 64'(count), 64'd7);
      nxt();
    end
    dispatch_valid = 1'b0;
    wait_empty(12);

    // Dispatch-time capture of a same-cycle wakeup on channel 1
    dispatch_valid = 1'b1; dispatch_entry = mk(24, 9, 0, 0, 0, 0); sb.push_back(5'd24);
    wb_en = 2'b10; wb_prd[1] = 6'd9;
    nxt();
    dispatch_valid = 1'b0; wb_en = '0;
    @(negedge clk);
    check("t4_capture_issue", 64'(issue_en), 64'd1);
    nxt();
    wait_empty(4);

    // Head waiting on prs1=4: bypass changes the wakeup-to-issue latency
    dispatch_valid = 1'b1; dispatch_entry = mk(25, 4, 0, 0, 0, 0); sb.push_back(5'd25);
    nxt();
    dispatch_valid = 1'b0;
    @(negedge clk);
    check("t5_waiting", 64'(issue_en), 64'd0);
    nxt();
    wb_en = 2'b01; wb_prd[0] = 6'd4;
    @(negedge clk);
    check("t5_same_cycle", 64'(issue_en), 64'(BYP));
    nxt();
    wb_en = '0;
    @(negedge clk);
    check("t5_next_cycle", 64'(issue_en), 64'(!BYP));
    nxt();
    wait_empty(4);

    // Flush with count=5 and a simultaneous dispatch
    lsu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dispatch_valid = 1'b1; dispatch_entry = mk(26 + i, 0, 1, 0, 0, 0);
      nxt();
    end
    flush = 1'b1; lsu_ready = 1'b1; dispatch_entry = mk(31, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("t6_pre_flush_count", 64'(count), 64'd5);
    check("t6_flush_no_issue", 64'(issue_en), 64'd0);
    nxt();
    flush = 1'b0; dispatch_valid = 1'b0;
    @(negedge clk);
    check("t6_post_flush_count", 64'(count), 64'd0);
    check("t6_post_flush_issue", 64'(issue_en), 64'd0);
    nxt();

    // Asynchronous reset mid-stream
    lsu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dispatch_valid = 1'b1; dispatch_entry = mk(1 + i, 0, 1, 0, 0, 0);
      nxt();
    end
    dispatch_valid = 1'b0;
    lsu_ready = 1'b1;
    #1;
    check("t7_pre_rst_issue", 64'(issue_en), 64'd1);
    check("t7_pre_rst_count", 64'(count), 64'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("t7_rst_issue_en", 64'(issue_en), 64'd0);
    check("t7_rst_count", 64'(count), 64'd0);
    check("t7_rst_dispatch_ready", 64'(dispatch_ready), 64'd1);
    check("t7_rst_issue_entry", 64'(issue_entry), 64'd0);
    lsu_ready = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;

    // Recovery after reset
    lsu_ready = 1'b1; dispatch_valid = 1'b1; dispatch_entry = mk(31, 0, 1, 0, 0, 0);
    sb.push_back(5'd31);
    nxt();
    dispatch_valid = 1'b0;
    wait_empty(4);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_issue_queue.md
# lsu_issue_queue

In-order issue queue for memory instructions, directly upstream of the load/store unit. Dispatch writes renamed loads/stores in program order. Entries track source-operand readiness from writeback broadcasts. Only the oldest entry may issue, and it issues when its operands are ready and the LSU accepts, so memory operations reach the LSU strictly in program order.

## Interface
Parameters:
- DEPTH, 8: entry count; power of two, ≥2.
- NUM_WB, 2: number of writeback broadcast channels used for wakeup.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dispatch_valid  in  1  a memory instruction is presented for insertion.
- dispatch_entry  in  rs_entry_t  renamed instruction: prs1, prs2, prs1_ready, prs2_ready, prd, rob_tag, immediate, mem_read, mem_write, reg_write.
- dispatch_ready  out  1  queue can accept this cycle.
- wb_en  in  NUM_WB  per-channel writeback valid.
- wb_prd  in  NUM_WB×PHYS_REG_BITS  per-channel destination physical register.
- lsu_ready  in  1  LSU accepts an issue this cycle.
- issue_en  out  1  head entry issued this cycle.
- issue_entry  out  rs_entry_t  head entry contents; drives LSU issue and PRF read ports.
- count  out  $clog2(DEPTH)+1  occupied entries.
- flush  in  1  discard all entries.

## Operation
- Circular buffer with head/tail pointers of $clog2(DEPTH) bits, which wrap naturally, plus a separate count register (0..DEPTH).
- Dispatch:
  - A dispatch occurs when dispatch_valid && dispatch_ready && !flush.
  - The entry is written at tail, tail increments.
  - Ready bits are captured as dispatch_entry.prsN_ready OR any same-cycle wb_en[i] with wb_prd[i]==prsN.
- dispatch_ready = (count < DEPTH). This is a registered-count comparison and does not credit a same-cycle issue, so a full queue rejects dispatch even while issuing.
- Wakeup:
  - Each cycle, every valid entry sets prsN_ready when any wb_en[i] matches prsN.
  - Physical register 0 is always ready.
- Issue eligibility applies to the head entry only:
  - Valid, and prs1_ready.
  - Additionally prs2_ready when mem_write=1. Loads ignore prs2.
- issue_en = eligible && lsu_ready && !flush. On issue, head increments and the entry is invalidated.
- Count update: +1 on dispatch only, −1 on issue only, unchanged when both or neither occur.
- Flush (synchronous, highest priority):
  - Clears all valid bits and sets head=tail=count=0.
  - No dispatch or issue occurs that cycle.
- No other state machine: the queue is empty, partially filled or full as derived from count.

## Timing
- Reset values: issue_en=0, dispatch_ready=1, count=0, issue_entry=all zeros, all entries invalid.
- Reset takes effect immediately on rst_n falling; operation resumes on the first rising edge after rst_n rises. Reset during in-flight entries discards them.
- issue_en and issue_entry are combinational from the registered head entry, lsu_ready, flush and (per Configuration) wb inputs.
- Dispatch at edge N: the entry is visible at head no earlier than cycle N+1. Minimum dispatch-to-issue latency with ready operands is 1 cycle.
- Wakeup on channel i in cycle N: the entry is ready from cycle N+1 without bypass, or in cycle N with bypass.
- Throughput: one dispatch and one issue per cycle.
- A blocked head (operand not ready or lsu_ready=0) stalls all younger entries.

## Configuration
- LSU_IQ_WAKEUP_BYPASS_EN defined: head eligibility also treats an operand as ready when a same-cycle wb_en[i]/wb_prd[i] matches it. This creates a combinational path from wb inputs to issue_en.
- LSU_IQ_WAKEUP_BYPASS_EN undefined: eligibility uses registered ready bits only, and there is no wb-to-issue_en path.
- Dispatch-time capture of same-cycle wakeups is present in both builds.

## Structure
- rs_entry_t, PHYS_REG_BITS and ROB_BITS live in ooo_types, with no new package types.
- The local per-entry struct (valid plus rs_entry_t) stays inside the module.
- One natural sub-module, lsu_iq_wakeup_match: compares one physical register tag against all NUM_WB channels and returns a hit. It is instantiated for prs1/prs2 of every entry and of the dispatch input.

## Test plan
- Reset, then dispatch a load with prs1=5 ready and lsu_ready=1: issue_en=1 the next cycle with a matching rob_tag; count goes 0→1→0.
- Store with prs1=3 ready and prs2=7 not ready, then a load behind it with prs1=3 ready: no issue until wb_en[0]=1, wb_prd[0]=7. The store issues before the load (in-order).
- Fill 8 entries with none ready: dispatch_ready=0 at count=8. Then wake all and hold dispatch_valid=1: dispatch is still rejected on the first issue cycle, and pointers wrap correctly across 12 further dispatches.
- Dispatch prs1=9 not ready while wb_en[1]=1, wb_prd[1]=9 in the same cycle: the entry issues the next cycle.
- Bypass build: head waiting on prs1=4, wb_prd[0]=4 pulsed: issue_en=1 in that same cycle. Non-bypass build: issue_en=1 one cycle later.
- Flush with count=5 and simultaneous dispatch_valid: count=0 and issue_en=0 the next cycle. Deassert rst_n mid-stream: outputs take reset values immediately.
